// File: rtl/rec_play_pkg.sv
// Shared types and width helpers for the multi-track record/playback controller.
// The only build option is REC_PLAY_LOOP_EN, which is consumed by rec_play_ctrl.
package rec_play_pkg;

   typedef enum logic [2:0] {
      S_INIT       = 3'd0,
      S_IDLE       = 3'd1,
      S_RECD       = 3'd2,
      S_RECD_PAUSE = 3'd3,
      S_PLAY       = 3'd4,
      S_PLAY_PAUSE = 3'd5
   } state_t;

   typedef struct packed {
      logic rec;
      logic play;
      logic paused;
   } status_t;

   // A single-track build still needs a 1-bit track select.
   function automatic int track_w(input int num_tracks);
      return (num_tracks > 1) ? $clog2(num_tracks) : 1;
   endfunction

   // log2 of the words per track partition.
   function automatic int depth_w(input int addr_w, input int num_tracks);
      return addr_w - $clog2(num_tracks);
   endfunction

   function automatic status_t status_of(input state_t s);
      case (s)
         S_RECD:       return status_t'(3'b100);
         S_RECD_PAUSE: return status_t'(3'b101);
         S_PLAY:       return status_t'(3'b010);
         S_PLAY_PAUSE: return status_t'(3'b011);
         default:      return status_t'(3'b000);
      endcase
   endfunction

endpackage

// File: rtl/rec_play_len_table.sv
// Per-track stored-length register file: one write port, one combinational read port.
// Every entry is cleared by reset.
module rec_play_len_table
   import rec_play_pkg::*;
#(
   parameter int NUM_TRACKS = 4,
   parameter int TRACK_W    = 2,
   parameter int LEN_W      = 19
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [TRACK_W-1:0] waddr,
   input  logic [LEN_W-1:0]   wdata,
   input  logic [TRACK_W-1:0] raddr,
   output logic [LEN_W-1:0]   rdata
);

   logic [LEN_W-1:0] len_mem [NUM_TRACKS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_TRACKS; i++) len_mem[i] <= '0;
      end else if (we) begin
         len_mem[waddr] <= wdata;
      end
   end

   assign rdata = len_mem[raddr];

endmodule

// File: rtl/rec_play_ctrl.sv
// Multi-track record/playback controller: keys and sample ticks in, SRAM address/strobe out.
// Build option: define REC_PLAY_LOOP_EN to make playback wrap at the track length instead of ending.
module rec_play_ctrl
   import rec_play_pkg::*;
#(
   parameter  int ADDR_W     = 20,
   parameter  int NUM_TRACKS = 4,
   parameter  int STEP_W     = 4,
   localparam int TRACK_W    = track_w(NUM_TRACKS),
   localparam int DEPTH_W    = depth_w(ADDR_W, NUM_TRACKS),
   localparam int LEN_W      = DEPTH_W + 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_init_done,
   input  logic               i_key_start,
   input  logic               i_key_stop,
   input  logic               i_key_pause,
   input  logic               i_mode,
   input  logic [TRACK_W-1:0] i_track_sel,
   input  logic               i_sample_tick,
   input  logic [STEP_W-1:0]  i_step,
   output logic [ADDR_W-1:0]  o_sram_addr,
   output logic               o_sram_we,
   output logic               o_rec_active,
   output logic               o_play_active,
   output logic               o_paused,
   output logic [LEN_W-1:0]   o_track_len,
   output logic               o_done,
   output logic [2:0]         o_state
);

   localparam int SUM_W = LEN_W + STEP_W;
   localparam logic [LEN_W-1:0] DEPTH = LEN_W'(1) << DEPTH_W;

   state_t             state;
   status_t            status;
   logic [TRACK_W-1:0] track_q;
   logic [LEN_W-1:0]   ptr;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   rd_len;
   logic               rec_end;
   logic               play_end;
   logic [STEP_W-1:0]  step_eff;
   logic [SUM_W-1:0]   ptr_sum;
   logic [ADDR_W-1:0]  cur_addr;

   // A recording session closes on stop or once the partition is full.
   assign rec_end = ((state == S_RECD) && (i_key_stop || (ptr == DEPTH))) ||
                    ((state == S_RECD_PAUSE) && i_key_stop);

`ifdef REC_PLAY_LOOP_EN
   assign play_end = i_key_stop;
`else
   assign play_end = i_key_stop || (ptr >= len_q);
`endif

   assign step_eff = (i_step == '0) ? STEP_W'(1) : i_step;
   assign ptr_sum  = SUM_W'(ptr) + SUM_W'(step_eff);
   assign cur_addr = (ADDR_W'(track_q) << DEPTH_W) | ADDR_W'(ptr[DEPTH_W-1:0]);

   rec_play_len_table #(
      .NUM_TRACKS (NUM_TRACKS),
      .TRACK_W    (TRACK_W),
      .LEN_W      (LEN_W)
   ) u_len_table (
      .clk   (i_clk),
      .rst   (i_rst),
      .we    (rec_end),
      .waddr (track_q),
      .wdata (ptr),
      .raddr (i_track_sel),
      .rdata (rd_len)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= S_INIT;
         status      <= status_of(S_INIT);
         track_q     <= '0;
         ptr         <= '0;
         len_q       <= '0;
         o_sram_addr <= '0;
         o_sram_we   <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         o_sram_we <= 1'b0;
         o_done    <= 1'b0;
         case (state)
            S_INIT: begin
               if (i_init_done) begin
                  state  <= S_IDLE;
                  status <= status_of(S_IDLE);
               end
            end
            S_IDLE: begin
               // Stop and pause outrank start even when they have nothing to act on.
               if (i_key_start && !i_key_stop && !i_key_pause) begin
                  track_q <= i_track_sel;
                  len_q   <= rd_len;
                  ptr     <= '0;
                  if (!i_mode) begin
                     state  <= S_RECD;
                     status <= status_of(S_RECD);
                  end else if (rd_len != '0) begin
                     state  <= S_PLAY;
                     status <= status_of(S_PLAY);
                  end
               end
            end
            S_RECD: begin
               if (rec_end) begin
                  state  <= S_IDLE;
                  status <= status_of(S_IDLE);
                  o_done <= 1'b1;
               end else if (i_key_pause) begin
                  state  <= S_RECD_PAUSE;
                  status <= status_of(S_RECD_PAUSE);
               end else if (i_sample_tick && !o_sram_we) begin
                  o_sram_we   <= 1'b1;
                  o_sram_addr <= cur_addr;
                  ptr         <= ptr + LEN_W'(1);
               end
            end
            S_RECD_PAUSE: begin
               if (rec_end) begin
                  state  <= S_IDLE;
                  status <= status_of(S_IDLE);
                  o_done <= 1'b1;
               end else if (i_key_start && !i_key_pause) begin
                  state  <= S_RECD;
                  status <= status_of(S_RECD);
               end
            end
            S_PLAY: begin
               if (play_end) begin
                  state  <= S_IDLE;
                  status <= status_of(S_IDLE);
                  o_done <= 1'b1;
               end else if (i_key_pause) begin
                  state  <= S_PLAY_PAUSE;
                  status <= status_of(S_PLAY_PAUSE);
`ifdef REC_PLAY_LOOP_EN
               end else if (ptr >= len_q) begin
                  ptr <= ptr - len_q;
               end else if (i_sample_tick) begin
                  o_sram_addr <= cur_addr;
                  ptr <= (ptr_sum >= SUM_W'(len_q)) ? LEN_W'(ptr_sum - SUM_W'(len_q))
                                                    : LEN_W'(ptr_sum);
               end
`else
               end else if (i_sample_tick) begin
                  o_sram_addr <= cur_addr;
                  // Clamping at the length keeps a large step from wrapping the counter.
                  ptr <= (ptr_sum >= SUM_W'(len_q)) ? len_q : LEN_W'(ptr_sum);
               end
`endif
            end
            S_PLAY_PAUSE: begin
               if (i_key_stop) begin
                  state  <= S_IDLE;
                  status <= status_of(S_IDLE);
                  o_done <= 1'b1;
               end else if (i_key_start && !i_key_pause) begin
                  state  <= S_PLAY;
                  status <= status_of(S_PLAY);
               end
            end
            default: begin
               state  <= S_INIT;
               status <= status_of(S_INIT);
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) o_track_len <= '0;
      else       o_track_len <= rd_len;
   end

   assign o_rec_active  = status.rec;
   assign o_play_active = status.play;
   assign o_paused      = status.paused;
   assign o_state       = state;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Scenario bench for rec_play_ctrl at ADDR_W=8, NUM_TRACKS=4 (64 words per track).
// Tick results go through an expected queue; state and flag checks are inline per scenario.
module tb_rec_play_ctrl;
   import rec_play_pkg::*;

   logic       clk = 1'b0;
   logic       rst, init_done, key_start, key_stop, key_pause, mode, tick;
   logic [1:0] track_sel;
   logic [3:0] step;
   logic [7:0] sram_addr;
   logic       sram_we, rec_active, play_active, paused, done;
   logic [6:0] track_len;
   logic [2:0] state_dbg;

   int n_vec = 0;
   int n_err = 0;
   logic [8:0] exp_q[$];   // {we, addr} expected one cycle after each tick

   rec_play_ctrl #(.ADDR_W(8), .NUM_TRACKS(4), .STEP_W(4)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_init_done   (init_done),
      .i_key_start   (key_start),
      .i_key_stop    (key_stop),
      .i_key_pause   (key_pause),
      .i_mode        (mode),
      .i_track_sel   (track_sel),
      .i_sample_tick (tick),
      .i_step        (step),
      .o_sram_addr   (sram_addr),
      .o_sram_we     (sram_we),
      .o_rec_active  (rec_active),
      .o_play_active (play_active),
      .o_paused      (paused),
      .o_track_len   (track_len),
      .o_done        (done),
      .o_state       (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic monitor_loop();
      logic       pend, wep;
      logic [8:0] e;
      forever begin
         @(posedge clk);
         pend = tick;
         wep  = sram_we;
         @(negedge clk);
         if (sram_we === 1'b1) begin
            n_vec++;
            if (wep === 1'b1) begin
               n_err++;
               $display("FAIL we_twice: o_sram_we=1 on consecutive cycles, required 0 at %0t", $time);
            end
         end
         if (pend) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL sb_empty: tick output we=%0b addr=%0d with nothing expected", sram_we, sram_addr);
            end else begin
               e = exp_q.pop_front();
               if ({sram_we, sram_addr} !== e) begin
                  n_err++;
                  $display("FAIL sb_tick: got we=%0b addr=%0d, want we=%0b addr=%0d at %0t",
                           sram_we, sram_addr, e[8], e[7:0], $time);
               end
            end
         end
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // One idle cycle, then a one-cycle tick (optionally with pause/stop) and its expected result.
   task automatic send_tick(input logic we, input logic [7:0] addr, input logic pause_k, input logic stop_k);
      @(negedge clk);
      tick = 1'b1; key_pause = pause_k; key_stop = stop_k;
      exp_q.push_back({we, addr});
      @(negedge clk);
      tick = 1'b0; key_pause = 1'b0; key_stop = 1'b0;
   endtask

   task automatic press_start(input logic m, input logic [1:0] t, input logic with_stop);
      mode = m; track_sel = t; key_start = 1'b1; key_stop = with_stop;
      @(negedge clk);
      key_start = 1'b0; key_stop = 1'b0;
   endtask

   task automatic press_stop();
      key_stop = 1'b1;
      @(negedge clk);
      key_stop = 1'b0;
   endtask

   task automatic press_pause();
      key_pause = 1'b1;
      @(negedge clk);
      key_pause = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; init_done = 1'b0;
      cycles(3);
      n_vec++;
      if ({sram_addr, sram_we, rec_active, play_active, paused, track_len, done} !== 20'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got addr=%0d we=%0b flags=%0b%0b%0b len=%0d done=%0b, want all 0",
                  sram_addr, sram_we, rec_active, play_active, paused, track_len, done);
      end
      n_vec++;
      if (state_dbg !== S_INIT) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_INIT); end
      rst = 1'b0;
      cycles(2);
      n_vec++;
      if (state_dbg !== S_INIT) begin n_err++; $display("FAIL init_wait: got %0d want %0d", state_dbg, S_INIT); end
      init_done = 1'b1;
      cycles(1);
      n_vec++;
      if (state_dbg !== S_IDLE) begin n_err++; $display("FAIL init_exit: got %0d want %0d", state_dbg, S_IDLE); end
   endtask

   task automatic test_record_play();
      press_start(1'b0, 2'd1, 1'b0);
      n_vec++;
      if (state_dbg !== S_RECD || rec_active !== 1'b1) begin
         n_err++; $display("FAIL rec_start: got state=%0d rec=%0b, want %0d 1", state_dbg, rec_active, S_RECD);
      end
      for (int i = 0; i < 10; i++) send_tick(1'b1, 8'(64 + i), 1'b0, 1'b0);
      press_stop();
      n_vec++;
      if (done !== 1'b1 || state_dbg !== S_IDLE || rec_active !== 1'b0) begin
         n_err++; $display("FAIL rec_stop: got done=%0b state=%0d rec=%0b, want 1 %0d 0", done, state_dbg, rec_active, S_IDLE);
      end
      cycles(1);
      n_vec++;
      if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse: got %0b want 0", done); end
      n_vec++;
      if (track_len !== 7'd10) begin n_err++; $display("FAIL len_t1: got %0d want 10", track_len); end
      track_sel = 2'd0;
      cycles(1);
      n_vec++;
      if (track_len !== 7'd0) begin n_err++; $display("FAIL len_t0: got %0d want 0", track_len); end
      press_start(1'b1, 2'd1, 1'b0);
      n_vec++;
      if (state_dbg !== S_PLAY || play_active !== 1'b1) begin
         n_err++; $display("FAIL play_start: got state=%0d play=%0b, want %0d 1", state_dbg, play_active, S_PLAY);
      end
      for (int i = 0; i < 10; i++) send_tick(1'b0, 8'(64 + i), 1'b0, 1'b0);
      cycles(1);
      n_vec++;
      if (done !== 1'b1 || state_dbg !== S_IDLE || play_active !== 1'b0) begin
         n_err++; $display("FAIL play_end: got done=%0b state=%0d play=%0b, want 1 %0d 0", done, state_dbg, play_active, S_IDLE);
      end
   endtask

   task automatic test_auto_stop();
      press_start(1'b0, 2'd3, 1'b0);
      for (int i = 0; i < 64; i++) send_tick(1'b1, 8'(192 + i), 1'b0, 1'b0);
      cycles(1);
      n_vec++;
      if (done !== 1'b1 || state_dbg !== S_IDLE) begin
         n_err++; $display("FAIL auto_stop: got done=%0b state=%0d, want 1 %0d", done, state_dbg, S_IDLE);
      end
      for (int i = 0; i < 6; i++) send_tick(1'b0, 8'd255, 1'b0, 1'b0);
      n_vec++;
      if (track_len !== 7'd64) begin n_err++; $display("FAIL len_t3: got %0d want 64", track_len); end
      track_sel = 2'd1;
      cycles(1);
      n_vec++;
      if (track_len !== 7'd10) begin n_err++; $display("FAIL len_t1_kept: got %0d want 10", track_len); end
   endtask

   task automatic test_pause();
      press_start(1'b1, 2'd1, 1'b0);
      for (int i = 0; i < 6; i++) send_tick(1'b0, 8'(64 + i), 1'b0, 1'b0);
      press_pause();
      n_vec++;
      if ({play_active, paused} !== 2'b11 || state_dbg !== S_PLAY_PAUSE) begin
         n_err++; $display("FAIL pause_enter: got play=%0b paused=%0b state=%0d, want 1 1 %0d", play_active, paused, state_dbg, S_PLAY_PAUSE);
      end
      press_pause();
      n_vec++;
      if (state_dbg !== S_PLAY_PAUSE) begin n_err++; $display("FAIL pause_again: got %0d want %0d", state_dbg, S_PLAY_PAUSE); end
      for (int i = 0; i < 3; i++) send_tick(1'b0, 8'd69, 1'b0, 1'b0);
      press_start(1'b0, 2'd2, 1'b0);
      n_vec++;
      if (paused !== 1'b0 || state_dbg !== S_PLAY) begin
         n_err++; $display("FAIL resume: got paused=%0b state=%0d, want 0 %0d", paused, state_dbg, S_PLAY);
      end
      send_tick(1'b0, 8'd70, 1'b0, 1'b0);
      send_tick(1'b0, 8'd70, 1'b1, 1'b0);
      n_vec++;
      if (paused !== 1'b1) begin n_err++; $display("FAIL tick_pause: got paused=%0b want 1", paused); end
      press_start(1'b0, 2'd2, 1'b0);
      press_start(1'b0, 2'd2, 1'b0);
      n_vec++;
      if (state_dbg !== S_PLAY) begin n_err++; $display("FAIL start_active: got %0d want %0d", state_dbg, S_PLAY); end
      send_tick(1'b0, 8'd71, 1'b0, 1'b0);
      press_stop();
      n_vec++;
      if (done !== 1'b1 || state_dbg !== S_IDLE) begin
         n_err++; $display("FAIL play_stop: got done=%0b state=%0d, want 1 %0d", done, state_dbg, S_IDLE);
      end
   endtask

   task automatic test_empty_play();
      press_start(1'b1, 2'd0, 1'b0);
      n_vec++;
      if (state_dbg !== S_IDLE || play_active !== 1'b0) begin
         n_err++; $display("FAIL empty_play: got state=%0d play=%0b, want %0d 0", state_dbg, play_active, S_IDLE);
      end
      cycles(1);
      n_vec++;
      if (state_dbg !== S_IDLE || done !== 1'b0) begin
         n_err++; $display("FAIL empty_hold: got state=%0d done=%0b, want %0d 0", state_dbg, done, S_IDLE);
      end
   endtask

   task automatic test_fast_play();
      press_start(1'b0, 2'd0, 1'b0);
      for (int i = 0; i < 10; i++) send_tick(1'b1, 8'(i), 1'b0, 1'b0);
      press_stop();
      step = 4'd3;
      press_start(1'b1, 2'd0, 1'b0);
      for (int i = 0; i < 4; i++) send_tick(1'b0, 8'(3 * i), 1'b0, 1'b0);
      cycles(1);
`ifdef REC_PLAY_LOOP_EN
      n_vec++;
      if (done !== 1'b0 || state_dbg !== S_PLAY) begin
         n_err++; $display("FAIL loop_cont: got done=%0b state=%0d, want 0 %0d", done, state_dbg, S_PLAY);
      end
      for (int i = 0; i < 3; i++) send_tick(1'b0, 8'(2 + 3 * i), 1'b0, 1'b0);
      press_stop();
`endif
      n_vec++;
      if (done !== 1'b1 || state_dbg !== S_IDLE) begin
         n_err++; $display("FAIL step3_end: got done=%0b state=%0d, want 1 %0d", done, state_dbg, S_IDLE);
      end
      step = 4'd0;
      press_start(1'b1, 2'd0, 1'b0);
      for (int i = 0; i < 3; i++) send_tick(1'b0, 8'(i), 1'b0, 1'b0);
      press_stop();
      n_vec++;
      if (done !== 1'b1) begin n_err++; $display("FAIL step0_stop: got done=%0b want 1", done); end
      step = 4'd1;
   endtask

   task automatic test_guards();
      press_start(1'b0, 2'd2, 1'b0);
      send_tick(1'b1, 8'd128, 1'b0, 1'b0);
      send_tick(1'b1, 8'd129, 1'b0, 1'b0);
      send_tick(1'b0, 8'd129, 1'b0, 1'b1);
      n_vec++;
      if (done !== 1'b1 || state_dbg !== S_IDLE) begin
         n_err++; $display("FAIL tick_stop: got done=%0b state=%0d, want 1 %0d", done, state_dbg, S_IDLE);
      end
      cycles(1);
      n_vec++;
      if (track_len !== 7'd2) begin n_err++; $display("FAIL len_tick_stop: got %0d want 2", track_len); end
      press_start(1'b0, 2'd2, 1'b0);
      send_tick(1'b1, 8'd128, 1'b0, 1'b0);
      press_start(1'b0, 2'd2, 1'b1);
      n_vec++;
      if (done !== 1'b1 || state_dbg !== S_IDLE) begin
         n_err++; $display("FAIL stop_start: got done=%0b state=%0d, want 1 %0d", done, state_dbg, S_IDLE);
      end
      cycles(1);
      n_vec++;
      if (track_len !== 7'd1) begin n_err++; $display("FAIL len_stop_start: got %0d want 1", track_len); end
   endtask

   task automatic test_reset_mid_record();
      press_start(1'b0, 2'd2, 1'b0);
      for (int i = 0; i < 3; i++) send_tick(1'b1, 8'(128 + i), 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (state_dbg !== S_INIT || {rec_active, sram_we, done} !== 3'b000 || sram_addr !== 8'd0) begin
         n_err++; $display("FAIL mid_reset: got state=%0d rec=%0b we=%0b done=%0b addr=%0d, want %0d 0 0 0 0",
                           state_dbg, rec_active, sram_we, done, sram_addr, S_INIT);
      end
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (state_dbg !== S_IDLE) begin n_err++; $display("FAIL post_reset: got %0d want %0d", state_dbg, S_IDLE); end
      for (int t = 0; t < 4; t++) begin
         track_sel = 2'(t);
         cycles(1);
         n_vec++;
         if (track_len !== 7'd0) begin n_err++; $display("FAIL len_cleared: track %0d got %0d want 0", t, track_len); end
      end
   endtask

   initial begin
      rst = 1'b1; init_done = 1'b0; key_start = 1'b0; key_stop = 1'b0; key_pause = 1'b0;
      mode = 1'b0; track_sel = 2'd0; tick = 1'b0; step = 4'd1;
      fork
         monitor_loop();
      join_none
      test_reset();
      test_record_play();
      test_auto_stop();
      test_pause();
      test_empty_play();
      test_fast_play();
      test_guards();
      test_reset_mid_record();
      cycles(3);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL sb_leftover: got %0d pending entries, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
